// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the issue/stall controller.
//   - opcode constants used by decode to classify instructions
//   - controller state encodings (RUN / DRAIN / FLUSH)
//   - scoreboard width and the hard-wired zero register
//   - reg_mask(): one-hot register mask helper
// Optional feature macro used by the importing files: HAZARD_CTRL_RETIRE_BYPASS_EN
package hazard_ctrl_pkg;

   // Opcode constants (RV32 major opcodes seen by decode)
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam int         SB_W     = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // One-hot mask for register a, or all zeros when en is low.
   function automatic logic [SB_W-1:0] reg_mask(input logic en, input logic [4:0] a);
      logic [SB_W-1:0] m;
      m = '0;
      if (en) m[a] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination register tracker.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clr_v, clr_addr       retire of a writing instruction (clears a bit)
//   set_v, set_addr       issue of a writing instruction (sets a bit, x0 ignored)
//   q1_addr..q3_addr      lookup addresses (rs1, rs2, rd)
//   q1_hit..q3_hit        register busy and not x0
//   empty                 no register busy
//   pending               registered scoreboard, bit n = register n in flight
// Macro HAZARD_CTRL_RETIRE_BYPASS_EN: lookups and empty ignore the register
// being retired this cycle.
module hazard_scoreboard
   import hazard_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_v,
   input  logic [4:0]      clr_addr,
   input  logic            set_v,
   input  logic [4:0]      set_addr,
   input  logic [4:0]      q1_addr,
   input  logic [4:0]      q2_addr,
   input  logic [4:0]      q3_addr,
   output logic            q1_hit,
   output logic            q2_hit,
   output logic            q3_hit,
   output logic            empty,
   output logic [SB_W-1:0] pending
);

   logic [SB_W-1:0] clr_mask;
   logic [SB_W-1:0] set_mask;
   logic [SB_W-1:0] view;

   assign clr_mask = reg_mask(clr_v, clr_addr);
   assign set_mask = reg_mask(set_v && (set_addr != REG_ZERO), set_addr);

   // Clear first, then set: a new writer of the retiring register keeps it busy.
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~clr_mask) | set_mask;
   end

`ifdef HAZARD_CTRL_RETIRE_BYPASS_EN
   // Register file write-through makes the retiring value readable this cycle.
   assign view = pending & ~clr_mask;
`else
   assign view = pending;
`endif

   assign q1_hit = (q1_addr != REG_ZERO) && view[q1_addr];
   assign q2_hit = (q2_addr != REG_ZERO) && view[q2_addr];
   assign q3_hit = (q3_addr != REG_ZERO) && view[q3_addr];
   assign empty  = (view == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: issue/stall controller for the single-issue pipeline.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_v, id_rs1/2, id_rs1/2_used    decoded instruction and its sources
//   id_rd, id_rd_we, id_serial       destination and serialising flag
//   redirect                         taken branch/jump resolved in execute
//   wb_done, wb_addr                 retire of a writing instruction
//   issue, stall_id                  combinational accept / hold decode
//   flush                            registered squash of fetch/decode
//   pending                          scoreboard of in-flight destinations
//   stall_cnt                        cycles with stall_id high (wrapping)
// Macro HAZARD_CTRL_RETIRE_BYPASS_EN: same-cycle retire satisfies a RAW/WAW
// and the drain empty test.
// Handshake: the decoded instruction is offered while id_v is high; it is
// consumed on a rising edge where issue is high, otherwise decode holds it
// when stall_id is high, or it is squashed when redirect/flush is active.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_v,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd,
   input  logic             id_rd_we,
   input  logic             id_serial,
   input  logic             redirect,
   input  logic             wb_done,
   input  logic [4:0]       wb_addr,
   output logic             issue,
   output logic             stall_id,
   output logic             flush,
   output logic [SB_W-1:0]  pending,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] fcnt;
   logic [3:0] fcnt_nxt;
   logic       rs1_hit;
   logic       rs2_hit;
   logic       rd_hit;
   logic       sb_empty;
   logic       hazard;

   hazard_scoreboard u_sb (
      .clk      (clk),
      .rst      (rst),
      .clr_v    (wb_done),
      .clr_addr (wb_addr),
      .set_v    (issue && id_rd_we),
      .set_addr (id_rd),
      .q1_addr  (id_rs1),
      .q2_addr  (id_rs2),
      .q3_addr  (id_rd),
      .q1_hit   (rs1_hit),
      .q2_hit   (rs2_hit),
      .q3_hit   (rd_hit),
      .empty    (sb_empty),
      .pending  (pending)
   );

   // RAW on either used source, WAW on the destination.
   assign hazard = (id_rs1_used && rs1_hit) ||
                   (id_rs2_used && rs2_hit) ||
                   (id_rd_we    && rd_hit);

   // State register, flush counter and registered flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         fcnt  <= '0;
         flush <= 1'b0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         flush <= (state_nxt == FLUSH);
      end
   end

   // Next state: a redirect overrides everything and (re)arms the window.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      if (redirect) begin
         state_nxt = FLUSH;
         fcnt_nxt  = FLUSH_LOAD;
      end else begin
         case (state)
            RUN:   if (id_v && id_serial) state_nxt = DRAIN;
            DRAIN: if (issue || !id_v) state_nxt = RUN;
            FLUSH: begin
               if (fcnt == 4'd1) begin
                  state_nxt = RUN;
                  fcnt_nxt  = '0;
               end else begin
                  fcnt_nxt = fcnt - 4'd1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // Outputs: a squash (redirect or flush window) is never reported as a stall.
   always_comb begin
      issue = 1'b0;
      case (state)
         RUN:     issue = id_v && !redirect && !hazard && !id_serial;
         DRAIN:   issue = id_v && !redirect && sb_empty;
         default: issue = 1'b0;
      endcase
      stall_id = id_v && !issue && !redirect && (state != FLUSH);
   end

   always_ff @(posedge clk) begin
      if (rst)           stall_cnt <= '0;
      else if (stall_id) stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// The driver applies inputs just after each rising edge, computes the
// expected outputs for that cycle from a behavioural model and queues them;
// the monitor pops one entry per falling edge and compares.
module tb_hazard_ctrl;

   localparam int FC = 2;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_v;
   logic [4:0]    id_rs1;
   logic [4:0]    id_rs2;
   logic          id_rs1_used;
   logic          id_rs2_used;
   logic [4:0]    id_rd;
   logic          id_rd_we;
   logic          id_serial;
   logic          redirect;
   logic          wb_done;
   logic [4:0]    wb_addr;
   logic          issue;
   logic          stall_id;
   logic          flush;
   logic [31:0]   pending;
   logic [CW-1:0] stall_cnt;

   hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_v        (id_v),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_rd       (id_rd),
      .id_rd_we    (id_rd_we),
      .id_serial   (id_serial),
      .redirect    (redirect),
      .wb_done     (wb_done),
      .wb_addr     (wb_addr),
      .issue       (issue),
      .stall_id    (stall_id),
      .flush       (flush),
      .pending     (pending),
      .stall_cnt   (stall_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef enum {M_RUN, M_DRAIN, M_FLUSH} mode_t;
   mode_t         m_mode;
   int            m_left;
   bit            m_pend[32];
   logic [CW-1:0] m_stalls;
   int            inflight[$];

   logic [66:0]   exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc_no = 0;

   task automatic model_reset();
      m_mode   = M_RUN;
      m_left   = 0;
      m_stalls = '0;
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      inflight.delete();
   endtask

   // One clock cycle with the currently driven inputs.
   task automatic step();
      bit          busy[32];
      bit          haz;
      bit          empty;
      bit          iss;
      bit          stl;
      logic [31:0] pend_vec;
      for (int r = 0; r < 32; r++) begin
         busy[r] = m_pend[r];
`ifdef HAZARD_CTRL_RETIRE_BYPASS_EN
         if (wb_done && int'(wb_addr) == r) busy[r] = 1'b0;
`endif
      end
      haz = (id_rs1_used && id_rs1 != 5'd0 && busy[id_rs1]) ||
            (id_rs2_used && id_rs2 != 5'd0 && busy[id_rs2]) ||
            (id_rd_we    && id_rd  != 5'd0 && busy[id_rd]);
      empty = 1'b1;
      for (int r = 0; r < 32; r++) if (busy[r]) empty = 1'b0;
      if (m_mode == M_FLUSH || redirect) iss = 1'b0;
      else if (m_mode == M_RUN)          iss = id_v && !haz && !id_serial;
      else                               iss = id_v && empty;
      stl = id_v && !iss && !redirect && (m_mode != M_FLUSH);
      for (int r = 0; r < 32; r++) pend_vec[r] = m_pend[r];
      exp_q.push_back({iss, stl, (m_mode == M_FLUSH), pend_vec, m_stalls});

      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         if (redirect) begin
            m_mode = M_FLUSH;
            m_left = FC;
         end else if (m_mode == M_FLUSH) begin
            if (m_left == 1) m_mode = M_RUN;
            else             m_left = m_left - 1;
         end else if (m_mode == M_RUN) begin
            if (id_v && id_serial) m_mode = M_DRAIN;
         end else if (iss || !id_v) begin
            m_mode = M_RUN;
         end
         if (wb_done) begin
            m_pend[wb_addr] = 1'b0;
            for (int i = 0; i < inflight.size(); i++)
               if (inflight[i] == int'(wb_addr)) begin
                  inflight.delete(i);
                  break;
               end
         end
         if (iss && id_rd_we && id_rd != 5'd0) begin
            m_pend[id_rd] = 1'b1;
            inflight.push_back(int'(id_rd));
         end
         if (stl) m_stalls = m_stalls + 1;
      end
      cyc_no++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rd, input logic we, input logic ser,
                      input logic redir, input logic wbd, input logic [4:0] wba);
      id_v        = v;
      id_rs1      = rs1;
      id_rs1_used = u1;
      id_rs2      = 5'd0;
      id_rs2_used = 1'b0;
      id_rd       = rd;
      id_rd_we    = we;
      id_serial   = ser;
      redirect    = redir;
      wb_done     = wbd;
      wb_addr     = wba;
      step();
   endtask

   task automatic rand_cyc();
      rst         = ($urandom_range(0, 299) == 0);
      id_v        = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_rd       = 5'($urandom_range(0, 7));
      id_rd_we    = 1'($urandom_range(0, 1));
      id_serial   = ($urandom_range(0, 19) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      wb_done     = (inflight.size() > 0) && ($urandom_range(0, 2) != 0);
      wb_addr     = wb_done ? 5'(inflight[0]) : 5'($urandom_range(0, 31));
      step();
      rst = 1'b0;
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc_no, act, exp);
      end
   endtask

   initial begin
      logic [66:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue",     64'(issue),     64'(e[66]));
            chk("stall_id",  64'(stall_id),  64'(e[65]));
            chk("flush",     64'(flush),     64'(e[64]));
            chk("pending",   64'(pending),   64'(e[63:32]));
            chk("stall_cnt", 64'(stall_cnt), 64'(e[31:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      cyc_no = 0;
      id_v = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = 0; id_rd_we = 0; id_serial = 0; redirect = 0; wb_done = 0; wb_addr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // RAW on x5: stall until retire
      cyc(1, 0, 0, 5, 1, 0, 0, 0, 0);
      repeat (3) cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 5, 1, 0, 0, 0, 0, 1, 5);
      cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // x0 writes and reads never hazard
      repeat (3) cyc(1, 0, 1, 0, 1, 0, 0, 0, 0);

      // single redirect, then back-to-back redirects
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // serialising drain behind x3 and x7
      cyc(1, 0, 0, 3, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 7, 1, 0, 0, 0, 0);
      repeat (2) cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 0, 1, 3);
      cyc(1, 0, 0, 0, 0, 1, 0, 1, 7);
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // set wins over a same-cycle clear of x9 (clear of a non-pending bit)
      cyc(1, 0, 0, 9, 1, 0, 0, 1, 9);
      cyc(1, 0, 0, 9, 1, 0, 0, 1, 9);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      while (inflight.size() > 0) cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'(inflight[0]));

      // reset while flushing with x4 pending
      cyc(1, 0, 0, 4, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
      rst = 1'b1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (2) cyc(1, 4, 1, 0, 0, 0, 0, 0, 0);

      // randomized traffic
      repeat (2000) rand_cyc();
      while (inflight.size() > 0) cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'(inflight[0]));
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Issue/stall controller for the single-issue pipeline.
- Keeps a 32-bit scoreboard of destination registers still in flight between decode and the write stage.
- Decides each cycle whether the decoded instruction may issue, and drives the stall into decode.
- Sequences branch-redirect flush windows and serialising drains.

Parameters:
FLUSH_CYCLES, 2, cycles flush is held after a redirect (1..15)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_v  in  1  decode holds a valid instruction
id_rs1  in  5  source register 1
id_rs2  in  5  source register 2
id_rs1_used  in  1  rs1 is read by the instruction
id_rs2_used  in  1  rs2 is read by the instruction
id_rd  in  5  destination register
id_rd_we  in  1  instruction writes rd
id_serial  in  1  serialising instruction (FENCE/SYSTEM): issues only with empty scoreboard
redirect  in  1  execute resolved a taken branch/jump this cycle
wb_done  in  1  write stage retires one writing instruction (killed or not)
wb_addr  in  5  rd of retiring instruction
issue  out  1  instruction accepted this cycle (combinational)
stall_id  out  1  decode must hold (combinational)
flush  out  1  squash fetch/decode contents (registered)
pending  out  32  scoreboard, bit n = register n in flight
stall_cnt  out  CNT_W  count of cycles with stall_id high

Behaviour:
- Reset values: state RUN, pending 0, flush 0, flush counter 0, stall_cnt 0. Reset mid-operation discards everything on that edge.
- Contract: every issued instruction with id_rd_we=1 and id_rd!=0 produces exactly one wb_done pulse with wb_addr=id_rd, including squashed ones.
- x0 never sets pending. A source equal to 0, or with its used flag low, never causes a hazard.
- hazard = (rs1_used & rs1!=0 & pending[rs1]) | (rs2_used & rs2!=0 & pending[rs2]) | (rd_we & rd!=0 & pending[rd]). The rd term is a WAW stall.
- RUN state:
  - issue = id_v & ~redirect & ~hazard & ~id_serial.
  - If id_v & id_serial & ~redirect: go to DRAIN, no issue that cycle.
- DRAIN state:
  - issue = id_v & ~redirect & (pending==0), then return to RUN.
  - id_v dropping while in DRAIN returns to RUN.
- FLUSH state:
  - Entered on any cycle with redirect=1, from any state; counter loads FLUSH_CYCLES.
  - flush=1 throughout FLUSH. issue=0.
  - Counter decrements each cycle; when it reaches 1, go to RUN next edge.
  - A redirect during FLUSH reloads the counter.
- stall_id = id_v & ~issue & ~redirect & state!=FLUSH. Squash is not stall.
- Scoreboard update each edge:
  - clear bit wb_addr if wb_done, then set bit id_rd if issue & id_rd_we & id_rd!=0.
  - Set wins on the same bit in the same cycle.
  - wb_done for an address not pending is ignored.
- stall_cnt increments when stall_id=1 and wraps modulo 2^CNT_W.
- Latency: a retire on cycle N is visible in the hazard check on cycle N+1. There is no bypass unless the optional feature is enabled.

Optional Feature:
- Macro HAZARD_CTRL_RETIRE_BYPASS_EN.
- Defined: the hazard check and DRAIN empty test use pending & ~(wb_done ? 1<<wb_addr : 0). A consumer can then issue in the same cycle its producer retires, saving one cycle per RAW. Only valid when the register file write-through covers that cycle.
- Undefined: the registered pending is used as stated above.

Decomposition:
- Shared header, alongside the existing opcode constants:
  - state encodings RUN=2'd0, DRAIN=2'd1, FLUSH=2'd2
  - REG_ZERO=5'd0
  - scoreboard width 32
- One natural sub-module, hazard_scoreboard:
  - owns the pending register and set/clear/priority logic
  - provides the combinational per-register lookup
- FSM, flush counter and stall counter stay in hazard_ctrl.

Test Plan:
- Issue rd=5, then next cycle rs1=5 used → stall_id=1 and issue=0 until wb_done with addr 5. Issue fires the following cycle (same cycle with bypass). stall_cnt equals the stall cycles.
- rd=0 writes and rs1=0 reads never set pending and never stall; pending stays 0.
- redirect on cycle N with FLUSH_CYCLES=2 → flush=1 on N+1 and N+2, issue=0 from N through N+2, RUN on N+3. A second redirect on N+1 extends flush to N+3.
- pending={3,7}, id_serial=1 → DRAIN, stall_id=1. Retire 3, then retire 7 → issue when pending==0, back to RUN.
- Same-cycle wb_done addr 9 and issue rd=9 → pending[9]=1 after the edge.
- rst asserted while in FLUSH with pending nonzero → next cycle state RUN, flush=0, pending=0, stall_cnt=0.
